// File: rtl/tuner_pkg.sv
// Shared types and constants for the guitar tuner front end.
package tuner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int PERIOD_WIDTH      = 20;
    localparam int CLK_HZ            = 50_000_000;
    localparam int DEFAULT_MIN_COUNT = 25_000;     // about 2 kHz at CLK_HZ
    localparam int DEFAULT_MAX_COUNT = 1_000_000;  // about 50 Hz at CLK_HZ

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous comparator output, followed by
// a rising-edge detector. edge_det is high for one cycle per synchronized rise.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic edge_det
);

    logic sync_1;
    logic sync_2;
    logic prev;

    // Synchronizer chain plus the delayed copy used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_1 <= sig_in;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign edge_det = sync_2 & ~prev;

endmodule

// File: rtl/period_counter.sv
// Measures the clk-cycle distance between accepted rising edges of the
// pickup comparator signal, rejecting glitches closer than MIN_COUNT and
// flagging loss of signal after MAX_COUNT cycles without an accepted edge.
module period_counter
    import tuner_pkg::*;
#(
    parameter int WIDTH     = PERIOD_WIDTH,
    parameter int MIN_COUNT = DEFAULT_MIN_COUNT,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             load,
    output logic             clear,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    logic             edge_det;
    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] period_n;
    logic             load_n;
    logic             clear_n;
    logic             timeout_n;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset    (reset),
        .sig_in   (sig_in),
        .edge_det (edge_det)
    );

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            period  <= '0;
            load    <= 1'b0;
            clear   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            period  <= period_n;
            load    <= load_n;
            clear   <= clear_n;
            timeout <= timeout_n;
        end
    end

    // Next-state logic; an edge at exactly MAX_COUNT wins over the timeout
    always_comb begin
        state_n   = state;
        count_n   = count;
        period_n  = period;
        load_n    = 1'b0;
        clear_n   = 1'b0;
        timeout_n = timeout;
        if (!enable) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    count_n = '0;
                    state_n = ARM;
                end
                ARM: begin
                    if (edge_det) begin
                        count_n = ONE_C;
                        state_n = MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_det && (count >= MIN_C)) begin
                        period_n  = count;
                        load_n    = 1'b1;
                        timeout_n = 1'b0;
                        count_n   = ONE_C;
                    end else if (edge_det) begin
                        count_n = count + ONE_C;
                    end else if (count == MAX_C) begin
                        clear_n   = 1'b1;
                        timeout_n = 1'b1;
                        count_n   = '0;
                        state_n   = ARM;
                    end else begin
                        count_n = count + ONE_C;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

endmodule
